inst_fetch: RTL

Instruction-fetch stage of the MIPS core. It owns the program counter and drives the instruction memory's `ce`/`addr` read port. It captures the returned word into the IF/ID pipeline register and applies stall, branch redirect (with delay slot) and flush/exception redirect. The instruction memory is combinational (data valid in the same cycle as `addr`), so the fetch stage is a single register stage.

---
 rtl/mips_pkg.sv | 15 +
 rtl/if_id_reg.sv | 34 +++
 rtl/inst_fetch.sv | 108 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM states and fetch-stage constants.
package mips_pkg;

   typedef enum logic [1:0] {
      FS_BOOT = 2'd0,
      FS_RUN  = 2'd1,
      FS_ERR  = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP_INST       = 32'h0000_0000;
   localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0080;
   localparam logic [31:0] PC_INC         = 32'd4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble overrides load, and holds when neither is set.
module if_id_reg
   import mips_pkg::*;
#(
   parameter logic [31:0] NOP = NOP_INST
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        bubble,
   input  logic [31:0] pc_in,
   input  logic [31:0] inst_in,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_valid
);

   // if_pc is left alone on a bubble; it is only meaningful when if_valid is set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_pc    <= 32'h0;
         if_inst  <= NOP;
         if_valid <= 1'b0;
      end else if (bubble) begin
         if_inst  <= NOP;
         if_valid <= 1'b0;
      end else if (load) begin
         if_pc    <= pc_in;
         if_inst  <= inst_in;
         if_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/inst_fetch.sv
// MIPS instruction-fetch stage: PC, fetch FSM, redirect/stall handling and
// misaligned-target trapping in front of a combinational instruction memory.
module inst_fetch
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
   parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
   parameter logic [31:0] NOP        = NOP_INST
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        inst_ce,
   output logic [31:0] inst_addr,
   input  logic [31:0] inst_data,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        flush,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_valid,
   output logic        fetch_err,
   output logic [31:0] err_pc
);

   fetch_state_e state, state_nx;
   logic [31:0]  pc, pc_nx, err_pc_nx;
   logic         err_nx, ld, bub, misalign;

   assign misalign  = branch_taken && (branch_target[1:0] != 2'b00);
   assign inst_ce   = (state == FS_RUN);
   assign inst_addr = pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= FS_BOOT;
         pc        <= RESET_PC;
         fetch_err <= 1'b0;
         err_pc    <= 32'h0;
      end else begin
         state     <= state_nx;
         pc        <= pc_nx;
         fetch_err <= err_nx;
         err_pc    <= err_pc_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      pc_nx     = pc;
      err_nx    = fetch_err;
      err_pc_nx = err_pc;
      ld        = 1'b0;
      bub       = 1'b0;
      case (state)
         FS_BOOT: begin
            state_nx = FS_RUN;
            if (flush) begin
               pc_nx  = EXC_VECTOR;
               bub    = 1'b1;
               err_nx = 1'b0;
            end
         end
         FS_RUN: begin
            if (flush) begin
               pc_nx  = EXC_VECTOR;
               bub    = 1'b1;
               err_nx = 1'b0;
            end else if (!stall) begin
               // the delay-slot word is latched on every unstalled cycle,
               // including the one that traps a misaligned target
               ld = 1'b1;
               if (misalign) begin
                  err_nx    = 1'b1;
                  err_pc_nx = branch_target;
                  state_nx  = FS_ERR;
               end else if (branch_taken) begin
                  pc_nx = branch_target;
               end else begin
                  pc_nx = pc + PC_INC;
               end
            end
         end
         FS_ERR: begin
            bub = 1'b1;
            if (flush) begin
               pc_nx    = EXC_VECTOR;
               err_nx   = 1'b0;
               state_nx = FS_RUN;
            end
         end
         default: state_nx = FS_BOOT;
      endcase
   end

   if_id_reg #(.NOP(NOP)) u_if_id (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ld),
      .bubble   (bub),
      .pc_in    (pc),
      .inst_in  (inst_data),
      .if_pc    (if_pc),
      .if_inst  (if_inst),
      .if_valid (if_valid)
   );

endmodule
